// File: rtl/rvfpm_issue_pkg.sv
// rvfpm_issue_pkg: shared opcode constants, queue entry record and the
// FP-opcode classifier used by the rvfpm issue queue.
package rvfpm_issue_pkg;

    // RISC-V major opcodes that belong to the F extension
    localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
    localparam logic [6:0] OPC_FMADD    = 7'b1000011;
    localparam logic [6:0] OPC_FMSUB    = 7'b1000111;
    localparam logic [6:0] OPC_FNMSUB   = 7'b1001011;
    localparam logic [6:0] OPC_FNMADD   = 7'b1001111;
    localparam logic [6:0] OPC_OP_FP    = 7'b1010011;

    // Default field widths of one queued instruction
    localparam int IQ_ID_W = 4;
    localparam int IQ_XLEN = 32;
    localparam int IQ_FLEN = 32;

    typedef struct packed {
        logic [31:0]        instr;
        logic [IQ_ID_W-1:0] id;
        logic [IQ_XLEN-1:0] rs;
        logic [IQ_FLEN-1:0] mem;
    } iq_entry_t;

    function automatic logic is_fp_opcode(input logic [6:0] opc);
        logic fp;
        case (opc)
            OPC_LOAD_FP, OPC_STORE_FP, OPC_FMADD, OPC_FMSUB,
            OPC_FNMSUB, OPC_FNMADD, OPC_OP_FP: fp = 1'b1;
            default:                           fp = 1'b0;
        endcase
        return fp;
    endfunction

endpackage

// File: rtl/rvfpm_issue_queue_if.sv
// rvfpm_issue_queue_if: core-side issue handshake plus FPU-side dispatch
// signals of the issue queue. slave = queue view, master = core/FPU view.
interface rvfpm_issue_queue_if #(
    parameter int DEPTH      = 4,
    parameter int X_ID_WIDTH = 4,
    parameter int XLEN       = 32,
    parameter int FLEN       = 32
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                  flush;
    logic                  issue_valid;
    logic                  issue_ready;
    logic [31:0]           issue_instr;
    logic [X_ID_WIDTH-1:0] issue_id;
    logic [XLEN-1:0]       issue_rs;
    logic [FLEN-1:0]       issue_mem;
    logic                  issue_accept;
    logic                  fpu_ready;
    logic                  enable;
    logic [31:0]           instruction;
    logic [X_ID_WIDTH-1:0] id;
    logic [XLEN-1:0]       data_fromXReg;
    logic [FLEN-1:0]       data_fromMem;
    logic [CW-1:0]         count;

    modport slave (
        input  flush, issue_valid, issue_instr, issue_id, issue_rs, issue_mem, fpu_ready,
        output issue_ready, issue_accept, enable, instruction, id, data_fromXReg,
               data_fromMem, count
    );

    modport master (
        output flush, issue_valid, issue_instr, issue_id, issue_rs, issue_mem, fpu_ready,
        input  issue_ready, issue_accept, enable, instruction, id, data_fromXReg,
               data_fromMem, count
    );
endinterface

// File: rtl/rvfpm_issue_fifo.sv
// rvfpm_issue_fifo: generic DEPTH x WIDTH FIFO with wrap-around pointers,
// occupancy counter and full/empty derived from the counter. clr empties
// the FIFO and wins over push/pop. Storage is not reset.
module rvfpm_issue_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Next pointers and occupancy; clear overrides everything
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer/occupancy registers, asynchronously cleared
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write; a cleared cycle discards the push
    always_ff @(posedge ck) begin
        if (push && !clr) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/rvfpm_issue_queue.sv
// rvfpm_issue_queue: in-order issue buffer in front of the rvfpm FPU.
// Classifies incoming instructions as FP / non-FP, queues FP ones and
// dispatches the head whenever the FPU is ready.
// Optional macro RVFPM_ISSUE_BYPASS_EN: an FP instruction arriving at an
// empty queue while the FPU is ready goes straight to the FPU outputs in
// the same cycle without being written.
module rvfpm_issue_queue
    import rvfpm_issue_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int X_ID_WIDTH = 4,
    parameter int XLEN       = 32,
    parameter int FLEN       = 32
) (
    input  logic                ck,
    input  logic                rst,
    rvfpm_issue_queue_if.slave  bus
);
    localparam int EW = 32 + X_ID_WIDTH + XLEN + FLEN;
    localparam int CW = $clog2(DEPTH + 1);

    logic          fp, hs, push, pop, byp;
    logic          full, empty;
    logic [EW-1:0] wdata, rdata;
    logic [CW-1:0] cnt;

    assign fp               = is_fp_opcode(bus.issue_instr[6:0]);
    assign bus.issue_accept = bus.issue_valid & fp;
    // Full is the registered state, so a same-cycle pop never frees a slot
    assign bus.issue_ready  = !full & !rst;
    assign hs               = bus.issue_valid & bus.issue_ready & bus.issue_accept & !bus.flush;
    assign pop              = !empty & bus.fpu_ready & !bus.flush;

`ifdef RVFPM_ISSUE_BYPASS_EN
    assign byp        = hs & empty & bus.fpu_ready;
    assign push       = hs & !byp;
    assign bus.enable = pop | byp;
`else
    assign byp        = 1'b0;
    assign push       = hs;
    assign bus.enable = pop;
`endif

    assign wdata     = {bus.issue_instr, bus.issue_id, bus.issue_rs, bus.issue_mem};
    assign bus.count = cnt;

    rvfpm_issue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .ck    (ck),
        .rst   (rst),
        .clr   (bus.flush),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .count (cnt),
        .full  (full),
        .empty (empty)
    );

    // FPU-side fields: head entry, bypassed issue fields, or zero when idle
    always_comb begin
        bus.instruction   = '0;
        bus.id            = '0;
        bus.data_fromXReg = '0;
        bus.data_fromMem  = '0;
        if (!empty) begin
            {bus.instruction, bus.id, bus.data_fromXReg, bus.data_fromMem} = rdata;
        end else if (byp) begin
            {bus.instruction, bus.id, bus.data_fromXReg, bus.data_fromMem} = wdata;
        end
    end

endmodule

// File: doc/rvfpm_issue_queue.md
Name: rvfpm_issue_queue

Overview:
- Upstream issue buffer feeding the rvfpm FPU core.
- Accepts offloaded instructions with their ID and operands over a valid/ready handshake, and classifies each as FP or non-FP.
- Queues accepted instructions in order and presents the head to the FPU as enable/instruction/id/data_fromXReg/data_fromMem whenever fpu_ready is high.
- Decouples core issue timing from FPU pipeline stalls.

Parameters:
- DEPTH, 4: queue entries; power of two, ≥2.
- X_ID_WIDTH, 4: instruction ID width.
- XLEN, 32: integer operand width.
- FLEN, 32: FP memory operand width.

Ports:
- ck  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  synchronous queue clear.
- issue_valid  in  1  core presents an instruction.
- issue_ready  out  1  queue can take an instruction this cycle.
- issue_instr  in  32  instruction word.
- issue_id  in  X_ID_WIDTH  instruction ID.
- issue_rs  in  XLEN  integer source operand.
- issue_mem  in  FLEN  memory load data.
- issue_accept  out  1  instruction is FP; valid while issue_valid.
- fpu_ready  in  1  FPU can take an instruction.
- enable  out  1  head entry dispatched to FPU this cycle.
- instruction  out  32  head instruction.
- id  out  X_ID_WIDTH  head ID.
- data_fromXReg  out  XLEN  head integer operand.
- data_fromMem  out  FLEN  head memory operand.
- count  out  $clog2(DEPTH+1)  occupancy.

Behaviour:
- Reset:
  - rst is asynchronous; all pointers and count go to 0.
  - Entry storage is not reset.
  - While rst is high, issue_ready=0 and enable=0.
  - Registered outputs come out of reset at 0. instruction/id/data outputs are 0 while empty.
- Classification (combinational): issue_accept=1 when opcode[6:0] ∈ {0000111 LOAD-FP, 0100111 STORE-FP, 1000011, 1000111, 1001011, 1001111 FMADD family, 1010011 OP-FP}; otherwise 0.
- Push:
  - Occurs at a rising edge when issue_valid & issue_ready & issue_accept & !flush.
  - A non-FP instruction completes the handshake (consumed by the core) but is not enqueued.
- issue_ready = !full & !rst.
  - Full is evaluated before any same-cycle pop, so no push occurs into a full queue even while popping.
- Dispatch:
  - enable = !empty & fpu_ready & !flush.
  - Head fields drive instruction/id/data_fromXReg/data_fromMem combinationally from storage.
  - Pop occurs at the edge where enable=1.
- Latency: with bypass off, an entry pushed at edge N can produce enable at the earliest in cycle N+1.
- Ordering: strict FIFO, IDs dispatched in push order.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers: $clog2(DEPTH) bits, natural wrap-around. Full/empty are derived from count (count==DEPTH / count==0).
- flush:
  - Sets count and both pointers to 0 at the next edge.
  - Has priority over push and pop.
  - enable is forced to 0 in the flush cycle.
- fpu_ready low: head is held stable and count does not decrease.
- Reset mid-operation drops every queued entry. No entry may be dispatched after reset is released.

Optional Feature:
- Macro RVFPM_ISSUE_BYPASS_EN, when defined:
  - When the queue is empty, fpu_ready=1, and an accepted FP instruction is pushed, the outputs take the issue_* fields directly.
  - enable=1 in the same cycle, and no entry is written (zero latency).
- When undefined: no combinational path from the issue_* inputs to the FPU-side outputs. Minimum latency is 1 cycle.

Decomposition:
- Package rvfpm_issue_pkg holds:
  - the opcode localparams;
  - the entry struct typedef {instr, id, rs, mem};
  - the function is_fp_opcode().
- One natural sub-module, rvfpm_issue_fifo: a generic storage array with pointers, count, and full/empty. The top adds classification, flush gating and bypass.

Test Plan:
- Reset, then issue 0x00208053 (FADD.S) with id=3, fpu_ready=1, no bypass → issue_accept=1, count=1 next cycle; enable=1, id=3, instruction=0x00208053 in cycle N+1; count=0 after.
- Issue 0x00000033 (ADD) → issue_accept=0, handshake completes, count stays 0, enable never rises.
- fpu_ready=0, push ids 0..3 (DEPTH=4) → count=4, issue_ready=0; fifth issue stalls. Raise fpu_ready → enable for ids 0,1,2,3 in order on consecutive cycles.
- Queue at 2 entries, push and dispatch in the same cycle → count stays 2; wrap pointers past index 3 without loss or reordering.
- 3 entries queued, assert flush with issue_valid=1 → next cycle count=0, no push, enable=0 in the flush cycle.
- Assert rst asynchronously mid-cycle with 2 entries queued → count=0, issue_ready=0, enable=0 immediately. After release, no stale IDs are dispatched. With RVFPM_ISSUE_BYPASS_EN, issuing into an empty queue gives enable=1 in the same cycle.
